// File: rtl/ota_cal_pkg.sv
// Shared types and constants for the OTA offset-trim SAR calibrator.
package ota_cal_pkg;

    // Calibration sequencer states
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_DECIDE  = 3'd2,
        S_NEXT_CH = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // Channel index width; fixed so the pinout does not move with N_CH
    localparam int CH_W = 2;

    // Mid-scale trim code: only the MSB set
    function automatic int MIDSCALE(input int w);
        return 1 << (w - 1);
    endfunction

    // Full-scale trim code: every bit set
    function automatic int ALLONES(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/ota_trim_sar_sync2.sv
// Two-flop synchroniser for the asynchronous comparator decision.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the async input through two flops; both clear on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ota_trim_sar.sv
// Multi-channel SAR offset-trim calibrator for comparator-mode OTAs,
// with a manual trim-load path usable while idle.
module ota_trim_sar
    import ota_cal_pkg::*;
#(
    parameter int TRIM_W     = 6,
    parameter int N_CH       = 2,
    parameter int SETTLE_CYC = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     cmp_in,
    input  logic                     load_en,
    input  logic [CH_W-1:0]          load_ch,
    input  logic [TRIM_W-1:0]        load_data,
    output logic [CH_W-1:0]          ch_sel,
    output logic [N_CH*TRIM_W-1:0]   trim_out,
    output logic                     busy,
    output logic                     done,
    output logic [N_CH-1:0]          cal_ok
);

    localparam int BIT_W = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
    localparam int CNT_W = $clog2(SETTLE_CYC);

    localparam logic [TRIM_W-1:0] MID      = TRIM_W'(MIDSCALE(TRIM_W));
    localparam logic [TRIM_W-1:0] FULL     = TRIM_W'(ALLONES(TRIM_W));
    localparam logic [BIT_W-1:0]  BIT_TOP  = BIT_W'(TRIM_W - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(N_CH - 1);

    state_t              state;
    logic [CH_W-1:0]     ch;
    logic [TRIM_W-1:0]   trial;
    logic [BIT_W-1:0]    bit_idx;
    logic [CNT_W-1:0]    cnt;
    logic                cmp_s;

    logic [TRIM_W-1:0]   bit_mask;
    logic [TRIM_W-1:0]   trial_dec;
    logic [TRIM_W-1:0]   trial_nxt;
    logic                last_bit;
    logic                idle_load;

    logic [N_CH-1:0][TRIM_W-1:0] trim_reg;

    sync2 u_cmp_sync (
        .clk (clk),
        .rst (rst),
        .d   (cmp_in),
        .q   (cmp_s)
    );

    // Trial-code update for the current bit: drop it on a "too high"
    // decision, then pre-set the next lower bit as the new guess
    always_comb begin
        bit_mask  = TRIM_W'(1) << bit_idx;
        trial_dec = cmp_s ? (trial & ~bit_mask) : trial;
        trial_nxt = trial_dec | (bit_mask >> 1);
        last_bit  = (bit_idx == '0);
        idle_load = (state == S_IDLE) && !start && load_en;
    end

    // Calibration sequencer: walks every channel, every bit, settle then decide
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            ch      <= '0;
            trial   <= MID;
            bit_idx <= BIT_TOP;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ch      <= '0;
                        trial   <= MID;
                        bit_idx <= BIT_TOP;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt == CNT_LAST) begin
                        state <= S_DECIDE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DECIDE: begin
                    if (last_bit) begin
                        trial <= trial_dec;
                        state <= S_NEXT_CH;
                    end else begin
                        trial   <= trial_nxt;
                        bit_idx <= bit_idx - 1'b1;
                        cnt     <= '0;
                        state   <= S_SETTLE;
                    end
                end
                S_NEXT_CH: begin
                    if (ch == CH_LAST) begin
                        state <= S_DONE;
                    end else begin
                        ch      <= ch + 1'b1;
                        trial   <= MID;
                        bit_idx <= BIT_TOP;
                        cnt     <= '0;
                        state   <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ch_sel = ch;

    // Per-channel trim register, result flag and output mux
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [TRIM_W-1:0] reg_q;
        logic              ok_q;
        logic              is_active;

        assign is_active = (ch == CH_W'(k));

        // Manual write when idle, SAR result on the final decision of this channel
        always_ff @(posedge clk) begin
            if (rst) begin
                reg_q <= MID;
                ok_q  <= 1'b0;
            end else if (idle_load && (load_ch == CH_W'(k))) begin
                reg_q <= load_data;
            end else if ((state == S_DECIDE) && last_bit && is_active) begin
                reg_q <= trial_dec;
                ok_q  <= (trial_dec != '0) && (trial_dec != FULL);
            end
        end

        assign trim_reg[k] = reg_q;
        assign cal_ok[k]   = ok_q;
        // The channel under calibration drives its live trial code to the DAC
        assign trim_out[k*TRIM_W +: TRIM_W] =
            ((state != S_IDLE) && is_active) ? trial : trim_reg[k];
    end

endmodule

// File: tb/tb_ota_trim_sar.sv
// Scoreboard bench for ota_trim_sar: a default instance (6b x 2ch) and a
// swept instance (8b x 4ch, short settle), each driven by a comparator model.
module tb_ota_trim_sar;
    import ota_cal_pkg::*;

    typedef struct {
        int          at;
        int          dut;
        string       name;
        logic [31:0] trim;
        logic [3:0]  ok;
        logic        busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    logic        start_a, cmp_a, load_en_a, busy_a, done_a;
    logic [1:0]  load_ch_a, ch_sel_a, cal_ok_a;
    logic [5:0]  load_data_a;
    logic [11:0] trim_a;

    logic        start_b, cmp_b, busy_b, done_b;
    logic [1:0]  ch_sel_b;
    logic [3:0]  cal_ok_b;
    logic [31:0] trim_b;

    int tgt_a [2];
    int tgt_b [4];

    exp_t tq[$];
    exp_t dq_a[$];
    exp_t dq_b[$];

    int n_vec = 0;
    int n_err = 0;
    int s0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ota_trim_sar #(.TRIM_W(6), .N_CH(2), .SETTLE_CYC(16)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .cmp_in(cmp_a),
        .load_en(load_en_a), .load_ch(load_ch_a), .load_data(load_data_a),
        .ch_sel(ch_sel_a), .trim_out(trim_a), .busy(busy_a), .done(done_a),
        .cal_ok(cal_ok_a)
    );

    ota_trim_sar #(.TRIM_W(8), .N_CH(4), .SETTLE_CYC(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .cmp_in(cmp_b),
        .load_en(1'b0), .load_ch(2'd0), .load_data(8'd0),
        .ch_sel(ch_sel_b), .trim_out(trim_b), .busy(busy_b), .done(done_b),
        .cal_ok(cal_ok_b)
    );

    // Comparator models: trip when the routed trial code exceeds the target offset
    always_comb begin
        cmp_a = (int'(trim_a[ch_sel_a*6 +: 6]) > tgt_a[ch_sel_a[0]]);
        cmp_b = (int'(trim_b[ch_sel_b*8 +: 8]) > tgt_b[ch_sel_b]);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Monitor: compare done pulses and timed snapshots against the queues
    always @(negedge clk) begin
        exp_t e;
        if (done_a === 1'b1) begin
            if (dq_a.size() == 0) begin
                chk("a_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = dq_a.pop_front();
                chk({e.name, "_cycle"}, 32'(cyc), 32'(e.at));
                chk({e.name, "_trim"},  {20'd0, trim_a}, e.trim);
                chk({e.name, "_calok"}, {30'd0, cal_ok_a}, {28'd0, e.ok});
            end
        end
        if (done_b === 1'b1) begin
            if (dq_b.size() == 0) begin
                chk("b_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = dq_b.pop_front();
                chk({e.name, "_cycle"}, 32'(cyc), 32'(e.at));
                chk({e.name, "_trim"},  trim_b, e.trim);
                chk({e.name, "_calok"}, {28'd0, cal_ok_b}, {28'd0, e.ok});
            end
        end
        while (tq.size() > 0 && tq[0].at <= cyc) begin
            e = tq.pop_front();
            chk({e.name, "_cycle"}, 32'(cyc), 32'(e.at));
            if (e.dut == 0) begin
                chk({e.name, "_trim"},  {20'd0, trim_a}, e.trim);
                chk({e.name, "_calok"}, {30'd0, cal_ok_a}, {28'd0, e.ok});
                chk({e.name, "_busy"},  {31'd0, busy_a}, {31'd0, e.busy});
            end else begin
                chk({e.name, "_trim"},  trim_b, e.trim);
                chk({e.name, "_calok"}, {28'd0, cal_ok_b}, {28'd0, e.ok});
                chk({e.name, "_busy"},  {31'd0, busy_b}, {31'd0, e.busy});
            end
        end
    end

    task automatic push_t(input int at, input int dut, input string name,
                          input logic [31:0] trim, input logic [3:0] ok, input logic busy);
        exp_t e;
        e.at = at; e.dut = dut; e.name = name; e.trim = trim; e.ok = ok; e.busy = busy;
        tq.push_back(e);
    endtask

    task automatic push_d(input int dut, input int lat, input string name,
                          input logic [31:0] trim, input logic [3:0] ok);
        exp_t e;
        e.at = s0 + lat; e.dut = dut; e.name = name; e.trim = trim; e.ok = ok; e.busy = 1'b0;
        if (dut == 0) dq_a.push_back(e);
        else          dq_b.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Pulse start on A; s0 becomes the edge that samples it
    task automatic launch_a;
        @(negedge clk);
        start_a = 1'b1;
        s0 = cyc + 1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    // Bounded wait for every queued expectation to be consumed
    task automatic drain(input int limit);
        int k = 0;
        while ((dq_a.size() + dq_b.size() + tq.size()) > 0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        if ((dq_a.size() + dq_b.size() + tq.size()) > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: %0d expectations outstanding, expected 0",
                     dq_a.size() + dq_b.size() + tq.size());
            dq_a.delete(); dq_b.delete(); tq.delete();
        end
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0; load_en_a = 1'b0; load_ch_a = 2'd0; load_data_a = 6'd0;
        start_b = 1'b0;
        tgt_a = '{37, 12};
        tgt_b = '{200, 1, 128, 77};

        // Reset state on both instances
        step(3);
        push_t(cyc + 1, 0, "reset_a", {20'd0, 6'd32, 6'd32}, 4'd0, 1'b0);
        push_t(cyc + 1, 1, "reset_b", 32'h80808080, 4'd0, 1'b0);
        step(2);
        rst = 1'b0;

        // SAR convergence with default parameters
        tgt_a = '{37, 12};
        launch_a();
        push_d(0, 207, "conv", {20'd0, 6'd12, 6'd37}, 4'b0011);
        drain(400);

        // Busy lockout: start + load mid-run must be ignored; live trial on ch0
        step(2);
        launch_a();
        push_t(s0 + 1, 0, "live_trial", {20'd0, 6'd12, 6'd32}, 4'b0011, 1'b1);
        push_d(0, 207, "lockout", {20'd0, 6'd12, 6'd37}, 4'b0011);
        wait_until(s0 + 149);
        start_a = 1'b1; load_en_a = 1'b1; load_ch_a = 2'd0; load_data_a = 6'd5;
        step(1);
        start_a = 1'b0; load_en_a = 1'b0;
        drain(400);

        // Reset mid-calibration
        step(2);
        launch_a();
        wait_until(s0 + 49);
        rst = 1'b1;
        push_t(cyc + 1, 0, "rst_mid", {20'd0, 6'd32, 6'd32}, 4'd0, 1'b0);
        step(1);
        rst = 1'b0;
        drain(10);

        // Saturation at both rails
        tgt_a = '{0, 63};
        launch_a();
        push_d(0, 207, "sat", {20'd0, 6'd63, 6'd0}, 4'b0000);
        drain(400);

        // Manual loads in IDLE: valid channel, then out-of-range channel
        step(1);
        load_en_a = 1'b1; load_ch_a = 2'd1; load_data_a = 6'd21;
        push_t(cyc + 1, 0, "load_ch1", {20'd0, 6'd21, 6'd0}, 4'b0000, 1'b0);
        step(1);
        load_ch_a = 2'd3; load_data_a = 6'd9;
        push_t(cyc + 1, 0, "load_ch3", {20'd0, 6'd21, 6'd0}, 4'b0000, 1'b0);
        step(1);
        load_ch_a = 2'd2;
        push_t(cyc + 1, 0, "load_ch2", {20'd0, 6'd21, 6'd0}, 4'b0000, 1'b0);
        step(1);
        load_en_a = 1'b0;
        drain(10);

        // start with load_en: load dropped, calibration runs
        tgt_a = '{37, 12};
        @(negedge clk);
        start_a = 1'b1; load_en_a = 1'b1; load_ch_a = 2'd1; load_data_a = 6'd44;
        s0 = cyc + 1;
        push_t(s0, 0, "start_vs_load", {20'd0, 6'd21, 6'd32}, 4'b0000, 1'b1);
        push_d(0, 207, "conv2", {20'd0, 6'd12, 6'd37}, 4'b0011);
        @(negedge clk);
        start_a = 1'b0; load_en_a = 1'b0;
        drain(400);

        // Parameter sweep instance
        @(negedge clk);
        start_b = 1'b1;
        s0 = cyc + 1;
        push_d(1, 133, "sweep", {8'd77, 8'd128, 8'd1, 8'd200}, 4'b1111);
        @(negedge clk);
        start_b = 1'b0;
        drain(300);

        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
